// File: rtl/btn_event_gen.sv
// Turns debounced button levels plus a shared 1 ms tick into one-clock
// press / release / long-press / auto-repeat pulses, one independent FSM per button.
module btn_event_gen #(
    parameter int N_BTN     = 3,
    parameter int LONG_MS   = 500,
    parameter int REPEAT_MS = 100,
    parameter int CNT_W     = 10
) (
    input  logic             clk_100Mhz,
    input  logic             rst,
    input  logic             tick,
    input  logic [N_BTN-1:0] btnDb,
    output logic [N_BTN-1:0] btnPress,
    output logic [N_BTN-1:0] btnRelease,
    output logic [N_BTN-1:0] btnLong,
    output logic [N_BTN-1:0] btnRepeat,
    output logic [N_BTN-1:0] btnHeld
);

    typedef enum logic [1:0] {IDLE, PRESS, HOLD} state_t;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_MS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_MS - 1);

    state_t           state_q [N_BTN];
    state_t           state_d [N_BTN];
    logic [CNT_W-1:0] cnt_q   [N_BTN];
    logic [CNT_W-1:0] cnt_d   [N_BTN];
    logic [N_BTN-1:0] armed_q;
    logic [N_BTN-1:0] press_d, release_d, long_d, repeat_d, held_d;

    // A button arms once it has been seen released, so one held through reset stays silent.
    always_ff @(posedge clk_100Mhz or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            armed_q    <= '0;
            btnPress   <= '0;
            btnRelease <= '0;
            btnLong    <= '0;
            btnRepeat  <= '0;
            btnHeld    <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            armed_q    <= armed_q | ~btnDb;
            btnPress   <= press_d;
            btnRelease <= release_d;
            btnLong    <= long_d;
            btnRepeat  <= repeat_d;
            btnHeld    <= held_d;
        end
    end

    // Release is tested before tick so a release cycle never also yields long/repeat.
    always_comb begin
        press_d   = '0;
        release_d = '0;
        long_d    = '0;
        repeat_d  = '0;
        held_d    = '0;
        for (int i = 0; i < N_BTN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (btnDb[i] && armed_q[i]) begin
                        press_d[i]  = 1'b1;
                        repeat_d[i] = 1'b1;
                        cnt_d[i]    = '0;
                        state_d[i]  = PRESS;
                    end
                end
                PRESS: begin
                    if (!btnDb[i]) begin
                        release_d[i] = 1'b1;
                        cnt_d[i]     = '0;
                        state_d[i]   = IDLE;
                    end else if (tick) begin
                        if (cnt_q[i] == LONG_LAST) begin
                            long_d[i]   = 1'b1;
                            repeat_d[i] = 1'b1;
                            cnt_d[i]    = '0;
                            state_d[i]  = HOLD;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (!btnDb[i]) begin
                        release_d[i] = 1'b1;
                        cnt_d[i]     = '0;
                        state_d[i]   = IDLE;
                    end else if (tick) begin
                        if (cnt_q[i] == REPEAT_LAST) begin
                            repeat_d[i] = 1'b1;
                            cnt_d[i]    = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    cnt_d[i]   = '0;
                    state_d[i] = IDLE;
                end
            endcase
            held_d[i] = (state_d[i] == HOLD);
        end
    end

endmodule

// File: tb/tb_btn_event_gen.sv
// Self-checking bench for btn_event_gen: directed scenarios plus a random
// run, all compared against a hold-time based reference model.
module tb_btn_event_gen;

    localparam int LONG  = 5;
    localparam int REP   = 2;

    logic       clk_100Mhz = 1'b0;
    logic       rst        = 1'b1;
    logic       tick       = 1'b0;
    logic [2:0] btnDb      = 3'b000;
    logic [2:0] btnPress, btnRelease, btnLong, btnRepeat, btnHeld;

    int tests_run    = 0;
    int tests_failed = 0;
    int tick_phase   = 0;

    logic [2:0] m_armed, m_active;
    int         m_h [3];
    logic [2:0] e_press, e_release, e_long, e_repeat, e_held;

    wire [14:0] obs_all = {btnPress, btnRelease, btnLong, btnRepeat, btnHeld};
    wire [14:0] exp_all = {e_press, e_release, e_long, e_repeat, e_held};

    btn_event_gen #(.N_BTN(3), .LONG_MS(LONG), .REPEAT_MS(REP), .CNT_W(10)) dut (
        .clk_100Mhz(clk_100Mhz),
        .rst       (rst),
        .tick      (tick),
        .btnDb     (btnDb),
        .btnPress  (btnPress),
        .btnRelease(btnRelease),
        .btnLong   (btnLong),
        .btnRepeat (btnRepeat),
        .btnHeld   (btnHeld)
    );

    always #5 clk_100Mhz = ~clk_100Mhz;

    task automatic model_reset();
        m_armed  = '0;
        m_active = '0;
        for (int i = 0; i < 3; i++) m_h[i] = 0;
        e_press = '0; e_release = '0; e_long = '0; e_repeat = '0; e_held = '0;
    endtask

    // Model tracks "ticks held since press"; long fires at LONG, repeats every REP after.
    task automatic model_step(input logic [2:0] b, input logic t);
        e_press = '0; e_release = '0; e_long = '0; e_repeat = '0; e_held = '0;
        for (int i = 0; i < 3; i++) begin
            if (!m_active[i]) begin
                if (b[i] && m_armed[i]) begin
                    m_active[i] = 1'b1;
                    m_h[i]      = 0;
                    e_press[i]  = 1'b1;
                    e_repeat[i] = 1'b1;
                end
            end else if (!b[i]) begin
                m_active[i]  = 1'b0;
                e_release[i] = 1'b1;
            end else if (t) begin
                m_h[i] = m_h[i] + 1;
                if (m_h[i] == LONG) begin
                    e_long[i]   = 1'b1;
                    e_repeat[i] = 1'b1;
                end else if (m_h[i] > LONG && ((m_h[i] - LONG) % REP) == 0) begin
                    e_repeat[i] = 1'b1;
                end
            end
            e_held[i] = m_active[i] && (m_h[i] >= LONG);
            if (!b[i]) m_armed[i] = 1'b1;
        end
    endtask

    task automatic run_cycle_t(input logic [2:0] b, input logic t);
        @(negedge clk_100Mhz);
        btnDb = b;
        tick  = t;
        @(posedge clk_100Mhz);
        if (!rst) model_step(b, t);
        #1;
    endtask

    task automatic run_cycle(input logic [2:0] b);
        logic t;
        t = (tick_phase % 10 == 9);
        tick_phase++;
        run_cycle_t(b, t);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        run_cycle(3'b000);
        run_cycle(3'b000);
        tests_run++;
        if (obs_all !== 15'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got %b expected %b", obs_all, 15'b0);
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            run_cycle(3'b000);
            tests_run++;
            if (obs_all !== exp_all) begin
                tests_failed++;
                $display("[TB] FAIL reset_idle: got %b expected %b", obs_all, exp_all);
            end
        end
    endtask

    task automatic test_press();
        run_cycle_t(3'b001, 1'b0);
        tests_run++;
        if ({btnPress, btnRepeat} !== {3'b001, 3'b001}) begin
            tests_failed++;
            $display("[TB] FAIL press_pulse: got press=%b repeat=%b expected 001/001", btnPress, btnRepeat);
        end
        for (int k = 0; k < 4; k++) begin
            run_cycle(3'b001);
            tests_run++;
            if (obs_all !== exp_all) begin
                tests_failed++;
                $display("[TB] FAIL press_width: got %b expected %b", obs_all, exp_all);
            end
        end
        run_cycle(3'b000);
        tests_run++;
        if (obs_all !== exp_all) begin
            tests_failed++;
            $display("[TB] FAIL press_release: got %b expected %b", obs_all, exp_all);
        end
    endtask

    task automatic test_long_repeat();
        int ticks = 0;
        int n_long, n_rep;
        run_cycle_t(3'b010, 1'b0);
        n_long = int'(btnLong[1]);
        n_rep  = int'(btnRepeat[1]);
        while (ticks < 12) begin
            if (tick_phase % 10 == 9) ticks++;
            run_cycle(3'b010);
            n_long += int'(btnLong[1]);
            n_rep  += int'(btnRepeat[1]);
            tests_run++;
            if (obs_all !== exp_all) begin
                tests_failed++;
                $display("[TB] FAIL long_repeat_cycle: got %b expected %b", obs_all, exp_all);
            end
        end
        tests_run++;
        if (n_long !== 1 || n_rep !== 5) begin
            tests_failed++;
            $display("[TB] FAIL long_repeat_count: got long=%0d repeat=%0d expected 1/5", n_long, n_rep);
        end
        tests_run++;
        if (btnHeld !== 3'b010) begin
            tests_failed++;
            $display("[TB] FAIL held_level: got %b expected 010", btnHeld);
        end
        run_cycle(3'b000);
        tests_run++;
        if (obs_all !== exp_all || btnHeld !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL long_release: got %b expected %b", obs_all, exp_all);
        end
    endtask

    task automatic test_release_vs_tick();
        run_cycle_t(3'b001, 1'b0);
        for (int k = 0; k < LONG - 1; k++) begin
            run_cycle_t(3'b001, 1'b0);
            run_cycle_t(3'b001, 1'b0);
            run_cycle_t(3'b001, 1'b1);
        end
        run_cycle_t(3'b000, 1'b1);
        tests_run++;
        if ({btnRelease, btnLong, btnRepeat, btnHeld} !== {3'b001, 3'b000, 3'b000, 3'b000}) begin
            tests_failed++;
            $display("[TB] FAIL release_beats_tick: got rel=%b long=%b rep=%b held=%b expected 001/000/000/000",
                     btnRelease, btnLong, btnRepeat, btnHeld);
        end
        tests_run++;
        if (obs_all !== exp_all) begin
            tests_failed++;
            $display("[TB] FAIL release_beats_tick_model: got %b expected %b", obs_all, exp_all);
        end
    endtask

    task automatic test_back_to_back();
        run_cycle_t(3'b001, 1'b0);
        tests_run++;
        if (btnPress !== 3'b001) begin
            tests_failed++;
            $display("[TB] FAIL b2b_press: got %b expected 001", btnPress);
        end
        run_cycle_t(3'b000, 1'b0);
        tests_run++;
        if (btnRelease !== 3'b001 || btnPress !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL b2b_release: got rel=%b press=%b expected 001/000", btnRelease, btnPress);
        end
    endtask

    task automatic test_held_through_reset();
        int events = 0;
        rst = 1'b1;
        model_reset();
        run_cycle(3'b100);
        run_cycle(3'b100);
        rst = 1'b0;
        for (int k = 0; k < 70; k++) begin
            run_cycle(3'b100);
            events += (obs_all != 15'b0) ? 1 : 0;
        end
        tests_run++;
        if (events !== 0) begin
            tests_failed++;
            $display("[TB] FAIL unarmed_silent: got %0d event cycles expected 0", events);
        end
        run_cycle(3'b000);
        tests_run++;
        if (obs_all !== 15'b0) begin
            tests_failed++;
            $display("[TB] FAIL unarmed_release: got %b expected %b", obs_all, 15'b0);
        end
        run_cycle(3'b000);
        run_cycle_t(3'b100, 1'b0);
        tests_run++;
        if (btnPress !== 3'b100 || obs_all !== exp_all) begin
            tests_failed++;
            $display("[TB] FAIL rearmed_press: got %b expected %b", obs_all, exp_all);
        end
        run_cycle(3'b000);
    endtask

    task automatic test_all_reset_mid_hold();
        int budget = 0;
        run_cycle(3'b000);
        run_cycle_t(3'b111, 1'b0);
        tests_run++;
        if (btnPress !== 3'b111) begin
            tests_failed++;
            $display("[TB] FAIL all_press: got %b expected 111", btnPress);
        end
        while (btnHeld !== 3'b111 && budget < 200) begin
            run_cycle(3'b111);
            budget++;
        end
        tests_run++;
        if (btnHeld !== 3'b111 || obs_all !== exp_all) begin
            tests_failed++;
            $display("[TB] FAIL all_hold: got %b expected %b", obs_all, exp_all);
        end
        #3;
        rst = 1'b1;
        #1;
        tests_run++;
        if (obs_all !== 15'b0) begin
            tests_failed++;
            $display("[TB] FAIL async_clear: got %b expected %b", obs_all, 15'b0);
        end
        model_reset();
        run_cycle(3'b111);
        run_cycle(3'b111);
        rst = 1'b0;
        for (int k = 0; k < 60; k++) begin
            run_cycle(3'b111);
            tests_run++;
            if (obs_all !== 15'b0) begin
                tests_failed++;
                $display("[TB] FAIL held_after_reset: got %b expected %b", obs_all, 15'b0);
            end
        end
        run_cycle(3'b000);
    endtask

    task automatic test_random();
        logic [2:0] b = 3'b000;
        logic       t;
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < 3; i++)
                if ($urandom_range(0, 29) == 0) b[i] = ~b[i];
            t = ($urandom_range(0, 4) == 0);
            run_cycle_t(b, t);
            tests_run++;
            if (obs_all !== exp_all) begin
                tests_failed++;
                $display("[TB] FAIL random_cycle%0d: got %b expected %b", k, obs_all, exp_all);
            end
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_long_repeat();
        test_release_vs_tick();
        test_back_to_back();
        test_held_through_reset();
        test_all_reset_mid_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
